// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: hazard inputs, memory handshake,
// and the pipeline-register enables it produces.
interface hazard_ctrl_if;
  logic [4:0]  IfId_rs_i;
  logic [4:0]  IfId_rt_i;
  logic [4:0]  IdEx_rt_i;
  logic        IdEx_MemRead_i;
  logic        Branch_i;
  logic        ExMem_MemAccess_i;
  logic        dmem_ack_i;
  logic        dmem_req_o;
  logic        PcWrite_o;
  logic        IfIdWrite_o;
  logic        IdExBubble_o;
  logic        IfIdFlush_o;
  logic        Freeze_o;
  logic        Err_o;
  logic [15:0] StallCnt_o;

  modport master (
    input  IfId_rs_i, IfId_rt_i, IdEx_rt_i, IdEx_MemRead_i, Branch_i,
           ExMem_MemAccess_i, dmem_ack_i,
    output dmem_req_o, PcWrite_o, IfIdWrite_o, IdExBubble_o, IfIdFlush_o,
           Freeze_o, Err_o, StallCnt_o
  );

  modport slave (
    output IfId_rs_i, IfId_rt_i, IdEx_rt_i, IdEx_MemRead_i, Branch_i,
           ExMem_MemAccess_i, dmem_ack_i,
    input  dmem_req_o, PcWrite_o, IfIdWrite_o, IdExBubble_o, IfIdFlush_o,
           Freeze_o, Err_o, StallCnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: freezes on outstanding data-memory accesses (with a
// timeout watchdog), bubbles on load-use, flushes IF/ID on taken branches.
module hazard_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.master hz
);

  typedef enum logic {RUN, WAIT} state_t;

  state_t      state;
  logic [7:0]  to_cnt;
  logic        err_q;
  logic [15:0] stall_cnt;

  logic req, freeze, load_use, timeout_hit, stall;

  always_comb begin
    timeout_hit = (state == WAIT) && !hz.dmem_ack_i && (to_cnt == 8'(TIMEOUT - 1));
    req         = (state == RUN) && hz.ExMem_MemAccess_i;
    freeze      = req || ((state == WAIT) && !hz.dmem_ack_i && !timeout_hit);
    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    load_use    = !freeze && hz.IdEx_MemRead_i && (hz.IdEx_rt_i != 5'd0) &&
                  ((hz.IdEx_rt_i == hz.IfId_rs_i) || (hz.IdEx_rt_i == hz.IfId_rt_i));
    stall       = freeze || load_use;
  end

  assign hz.dmem_req_o   = req;
  assign hz.Freeze_o     = freeze;
  assign hz.PcWrite_o    = !stall;
  assign hz.IfIdWrite_o  = !stall;
  assign hz.IdExBubble_o = load_use;
  assign hz.IfIdFlush_o  = !stall && hz.Branch_i;
  assign hz.Err_o        = err_q;
  assign hz.StallCnt_o   = stall_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= RUN;
      to_cnt    <= 8'd0;
      err_q     <= 1'b0;
      stall_cnt <= 16'd0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      case (state)
        RUN: if (hz.ExMem_MemAccess_i) begin
          state  <= WAIT;
          to_cnt <= 8'd0;
        end
        WAIT: begin
          to_cnt <= to_cnt + 8'd1;
          if (hz.dmem_ack_i) begin
            state <= RUN;
          end else if (timeout_hit) begin
            state <= RUN;
            err_q <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for the combinational hazard
// logic plus hand-written memory-stall, timeout and reset sequences.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if hz();
  hazard_ctrl #(.TIMEOUT(4)) dut (.clk_i(clk), .rst_i(rst), .hz(hz));

  typedef struct {
    logic [4:0] idex_rt, rs, rt;
    logic       memread, branch;
    logic       pc, ifid, bub, flush;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    hz.IfId_rs_i = 0; hz.IfId_rt_i = 0; hz.IdEx_rt_i = 0; hz.IdEx_MemRead_i = 0;
    hz.Branch_i = 0; hz.ExMem_MemAccess_i = 0; hz.dmem_ack_i = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_main(input string tag, input logic pc, input logic ifid,
                          input logic bub, input logic flush, input logic frz, input logic req);
    chk({tag, ".pc"},     32'(hz.PcWrite_o),    32'(pc));
    chk({tag, ".ifid"},   32'(hz.IfIdWrite_o),  32'(ifid));
    chk({tag, ".bubble"}, 32'(hz.IdExBubble_o), 32'(bub));
    chk({tag, ".flush"},  32'(hz.IfIdFlush_o),  32'(flush));
    chk({tag, ".freeze"}, 32'(hz.Freeze_o),     32'(frz));
    chk({tag, ".req"},    32'(hz.dmem_req_o),   32'(req));
  endtask

  vec_t vt [9];
  int   fz;

  initial begin
    //          idex_rt rs  rt  mrd br   pc ifid bub flush
    vt[0] = '{5'd0,  5'd0,  5'd0,  0, 0,  1, 1, 0, 0};
    vt[1] = '{5'd5,  5'd5,  5'd0,  1, 0,  0, 0, 1, 0};
    vt[2] = '{5'd0,  5'd0,  5'd0,  1, 0,  1, 1, 0, 0};
    vt[3] = '{5'd7,  5'd3,  5'd7,  1, 0,  0, 0, 1, 0};
    vt[4] = '{5'd7,  5'd3,  5'd4,  1, 0,  1, 1, 0, 0};
    vt[5] = '{5'd5,  5'd5,  5'd0,  0, 0,  1, 1, 0, 0};
    vt[6] = '{5'd5,  5'd5,  5'd0,  1, 1,  0, 0, 1, 0};
    vt[7] = '{5'd5,  5'd0,  5'd0,  0, 1,  1, 1, 0, 1};
    vt[8] = '{5'd31, 5'd31, 5'd31, 1, 0,  0, 0, 1, 0};

    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.err", 32'(hz.Err_o), 0);
    chk("rst.cnt", 32'(hz.StallCnt_o), 0);
    chk_main("rst", 1, 1, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk_main("rel", 1, 1, 0, 0, 0, 0);
    chk("rel.cnt", 32'(hz.StallCnt_o), 0);

    for (int i = 0; i < 9; i++) begin
      hz.IdEx_rt_i = vt[i].idex_rt; hz.IfId_rs_i = vt[i].rs; hz.IfId_rt_i = vt[i].rt;
      hz.IdEx_MemRead_i = vt[i].memread; hz.Branch_i = vt[i].branch;
      #1;
      chk_main($sformatf("vec%0d", i), vt[i].pc, vt[i].ifid, vt[i].bub, vt[i].flush, 0, 0);
      if (vt[i].bub) exp_cnt++;
      tick();
      chk($sformatf("vec%0d.cnt", i), 32'(hz.StallCnt_o), 32'(exp_cnt));
    end

    // Memory access with ack three cycles after the request; load-use held during freeze.
    clr();
    hz.ExMem_MemAccess_i = 1; hz.IdEx_MemRead_i = 1; hz.IdEx_rt_i = 5; hz.IfId_rs_i = 5;
    #1; chk_main("memN", 0, 0, 0, 0, 1, 1);
    tick(); hz.ExMem_MemAccess_i = 0;
    #1; chk_main("memN1", 0, 0, 0, 0, 1, 0);
    tick();
    #1; chk_main("memN2", 0, 0, 0, 0, 1, 0);
    tick(); clr(); hz.dmem_ack_i = 1;
    #1; chk_main("memAck", 1, 1, 0, 0, 0, 0);
    exp_cnt += 3;
    tick();
    chk("mem.cnt", 32'(hz.StallCnt_o), 32'(exp_cnt));

    // Back-to-back access with minimum (one-cycle) stall.
    hz.dmem_ack_i = 0; hz.ExMem_MemAccess_i = 1;
    #1; chk_main("b2b", 0, 0, 0, 0, 1, 1);
    tick(); hz.ExMem_MemAccess_i = 0; hz.dmem_ack_i = 1;
    #1; chk_main("b2bAck", 1, 1, 0, 0, 0, 0);
    exp_cnt += 1;
    tick(); hz.dmem_ack_i = 0;
    chk("b2b.cnt", 32'(hz.StallCnt_o), 32'(exp_cnt));
    chk("b2b.err", 32'(hz.Err_o), 0);

    // Timeout: no ack ever arrives.
    fz = 0;
    hz.ExMem_MemAccess_i = 1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (hz.Freeze_o) fz++;
      if (c == 4) chk("to.err_pre", 32'(hz.Err_o), 0);
      tick(); hz.ExMem_MemAccess_i = 0;
      if (c == 4) chk("to.err_set", 32'(hz.Err_o), 1);
    end
    chk("to.freeze_cycles", 32'(fz), 4);
    exp_cnt += 4;
    chk("to.cnt", 32'(hz.StallCnt_o), 32'(exp_cnt));
    hz.dmem_ack_i = 1;
    #1; chk_main("lateAck", 1, 1, 0, 0, 0, 0);
    tick(); hz.dmem_ack_i = 0;
    chk("lateAck.err", 32'(hz.Err_o), 1);
    chk("lateAck.cnt", 32'(hz.StallCnt_o), 32'(exp_cnt));

    // Async reset in the middle of WAIT.
    hz.ExMem_MemAccess_i = 1;
    tick(); hz.ExMem_MemAccess_i = 0;
    #1; chk("wait.freeze", 32'(hz.Freeze_o), 1);
    #1; rst = 1'b0;
    #1;
    chk_main("arst", 1, 1, 0, 0, 0, 0);
    chk("arst.err", 32'(hz.Err_o), 0);
    chk("arst.cnt", 32'(hz.StallCnt_o), 0);
    tick(); rst = 1'b1;
    tick();
    hz.ExMem_MemAccess_i = 1;
    #1; chk_main("post", 0, 0, 0, 0, 1, 1);
    tick(); hz.ExMem_MemAccess_i = 0;
    chk("post.cnt", 32'(hz.StallCnt_o), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
